retospect_tickgen: RTL and testbench

RETOSPECT_TICKGEN -- requirements
Module: retospect_tickgen

---
 rtl/retospect_fpna_pkg.sv | 30 +++
 rtl/retospect_tickgen_if.sv | 26 ++
 rtl/retospect_tickchan.sv | 65 ++++++
 rtl/retospect_tickgen.sv | 46 ++++
 tb/tb_retospect_tickgen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/retospect_fpna_pkg.sv
// Shared constants, operation decode and sizing helper for the tick generator.
package retospect_fpna_pkg;

  localparam int DEF_NCH = 6;
  localparam int DEF_CW  = 8;

  // Fixed tickbus lanes ahead of the channel lanes
  localparam int NEVER  = 0;
  localparam int ALWAYS = 1;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_RUN,
    OP_SHIFT,
    OP_CLEAR
  } op_e;

  function automatic int chain_len(input int nch, input int cw);
    return nch * (cw + 1);
  endfunction

  // Clear beats shifting, shifting beats running
  function automatic op_e decode_op(input logic clr, input logic cfg, input logic run);
    if (clr) return OP_CLEAR;
    if (cfg) return OP_SHIFT;
    if (run) return OP_RUN;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/retospect_tickgen_if.sv
// Configuration chain and tick output bundle of the tick generator.
interface retospect_tickgen_if
  import retospect_fpna_pkg::*;
#(
  parameter int NCH = DEF_NCH
) ();

  logic           config_en;
  logic           bs_in;
  logic           bs_out;
  logic           sync_clr;
  logic           run_en;
  logic [NCH+1:0] tickbus;
  logic           any_tick;

  modport master (
    output config_en, bs_in, sync_clr, run_en,
    input  bs_out, tickbus, any_tick
  );

  modport slave (
    input  config_en, bs_in, sync_clr, run_en,
    output bs_out, tickbus, any_tick
  );

endinterface

// File: rtl/retospect_tickchan.sv
// One tick channel: serial config word, period counter, oneshot done flag, tick flop.
module retospect_tickchan
  import retospect_fpna_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic clk,
  input  logic rst_n,
  input  op_e  op,
  input  logic sin,
  output logic sout,
  output logic tick,
  output logic tick_nxt
);

  logic [CW:0]   cfg, cfg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done, done_nxt;
  logic [CW-1:0] period;
  logic          oneshot;

  assign period  = cfg[CW-1:0];
  assign oneshot = cfg[CW];
  assign sout    = cfg[0];

  // tick_nxt also feeds the shared any_tick flop so both stay cycle-aligned
  always_comb begin
    cfg_nxt  = cfg;
    cnt_nxt  = cnt;
    done_nxt = done;
    tick_nxt = 1'b0;
    case (op)
      OP_CLEAR: begin
        cnt_nxt  = '0;
        done_nxt = 1'b0;
      end
      OP_SHIFT: cfg_nxt = {sin, cfg[CW:1]};
      OP_RUN: begin
        if (cnt == period) begin
          cnt_nxt  = '0;
          tick_nxt = ~done;
          if (oneshot) done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      tick <= 1'b0;
    end else begin
      cfg  <= cfg_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
      tick <= tick_nxt;
    end
  end

endmodule

// File: rtl/retospect_tickgen.sv
// Programmable multi-channel tick generator with a daisy-chained serial config chain.
module retospect_tickgen
  import retospect_fpna_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
) (
  input logic               clk,
  input logic               rst_n,
  retospect_tickgen_if.slave tg
);

  op_e            op;
  logic [NCH:0]   link;
  logic [NCH-1:0] ticks;
  logic [NCH-1:0] ticks_nxt;

  assign op      = decode_op(tg.sync_clr, tg.config_en, tg.run_en);
  assign link[0] = tg.bs_in;
  assign tg.bs_out = link[NCH];

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_chan
      retospect_tickchan #(.CW(CW)) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .sin      (link[k]),
        .sout     (link[k+1]),
        .tick     (ticks[k]),
        .tick_nxt (ticks_nxt[k])
      );
    end
  endgenerate

  assign tg.tickbus[NEVER]     = 1'b0;
  assign tg.tickbus[ALWAYS]    = 1'b1;
  assign tg.tickbus[NCH+1:2]   = ticks;

  always_ff @(posedge clk) begin
    if (!rst_n) tg.any_tick <= 1'b0;
    else        tg.any_tick <= |ticks_nxt;
  end

endmodule

// File: tb/tb_retospect_tickgen.sv
// Directed self-checking bench for retospect_tickgen at default and extreme parameters.
module tb_retospect_tickgen;
  import retospect_fpna_pkg::*;

  localparam int NA = 6,  CA = 8;
  localparam int NB = 1,  CB = 2;
  localparam int NC = 16, CC = 16;
  localparam int LA = NA * (CA + 1);
  localparam int LC = NC * (CC + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  retospect_tickgen_if #(.NCH(NA)) bus_a ();
  retospect_tickgen_if #(.NCH(NB)) bus_b ();
  retospect_tickgen_if #(.NCH(NC)) bus_c ();

  retospect_tickgen #(.NCH(NA), .CW(CA)) dut_a (.clk(clk), .rst_n(rst_n), .tg(bus_a));
  retospect_tickgen #(.NCH(NB), .CW(CB)) dut_b (.clk(clk), .rst_n(rst_n), .tg(bus_b));
  retospect_tickgen #(.NCH(NC), .CW(CC)) dut_c (.clk(clk), .rst_n(rst_n), .tg(bus_c));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cfg, input logic bsin, input logic clr, input logic run);
    bus_a.config_en = cfg;
    bus_a.bs_in     = bsin;
    bus_a.sync_clr  = clr;
    bus_a.run_en    = run;
    step();
  endtask

  task automatic loadMain(input logic [LA-1:0] vec);
    for (int i = 0; i < LA; i++) applyStimulus(1'b1, vec[i], 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [LA-1:0] pat, got;
    logic [LC-1:0] vecC;
    logic [5:0]    tickOr;
    int            cnt, first, total;

    rst_n = 1'b0;
    {bus_a.config_en, bus_a.bs_in, bus_a.sync_clr, bus_a.run_en} = '0;
    {bus_b.config_en, bus_b.bs_in, bus_b.sync_clr, bus_b.run_en} = '0;
    {bus_c.config_en, bus_c.bs_in, bus_c.sync_clr, bus_c.run_en} = '0;
    step();
    step();
    checkOutput("rst_tickbus", 64'(bus_a.tickbus), 64'h02);
    checkOutput("rst_any", 64'(bus_a.any_tick), 64'h0);
    checkOutput("rst_bsout", 64'(bus_a.bs_out), 64'h0);
    rst_n = 1'b1;

    // Reset config is P=0 everywhere: every run cycle ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("p0_all", 64'(bus_a.tickbus), 64'hFE);
    checkOutput("p0_any", 64'(bus_a.any_tick), 64'h1);

    loadMain({9'h003, 45'h0});
    checkOutput("shift_quiet", 64'(bus_a.tickbus), 64'h02);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("p3_edge%0d", e), 64'(bus_a.tickbus),
                  64'({5'b11111, (e % 4 == 0), 2'b10}));
    end

    // Oneshot on channel 1
    loadMain({9'h000, 9'h102, 36'h0});
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      first = 0;
      for (int e = 1; e <= 20; e++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        if (bus_a.tickbus[3]) begin
          cnt++;
          if (first == 0) first = e;
        end
      end
      checkOutput($sformatf("oneshot_count%0d", pass), 64'(cnt), 64'd1);
      checkOutput($sformatf("oneshot_edge%0d", pass), 64'(first), 64'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Stall at cnt=100 with P=255
    loadMain({9'h0FF, 45'h0});
    total = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
    end
    checkOutput("stall_tickbus", 64'(bus_a.tickbus), 64'h02);
    checkOutput("stall_any", 64'(bus_a.any_tick), 64'h0);
    while (!bus_a.tickbus[2] && total < 400) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
    end
    checkOutput("stall_first_tick", 64'(total), 64'd266);
    total = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
    end while (!bus_a.tickbus[2] && total < 400);
    checkOutput("wrap_period", 64'(total), 64'd256);

    // Chain readback
    pat = 54'h2D5A3C9F017E6B;
    tickOr = '0;
    for (int i = 0; i < LA; i++) begin
      applyStimulus(1'b1, pat[i], 1'b0, 1'b0);
      tickOr |= bus_a.tickbus[7:2];
    end
    got[0] = bus_a.bs_out;
    for (int j = 1; j < LA; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickOr |= bus_a.tickbus[7:2];
      got[j] = bus_a.bs_out;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("readback", 64'(got), 64'(pat));
    checkOutput("readback_quiet", 64'(tickOr), 64'h0);
    checkOutput("chain_flushed", 64'(bus_a.bs_out), 64'h0);

    // config_en with sync_clr: clear only, so P=3 survives and count restarts
    loadMain({9'h003, 45'h0});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    first = 0;
    for (int e = 1; e <= 8 && first == 0; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (bus_a.tickbus[2]) first = e;
    end
    checkOutput("clr_over_cfg", 64'(first), 64'd4);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_run_tickbus", 64'(bus_a.tickbus), 64'h02);
    checkOutput("rst_run_any", 64'(bus_a.any_tick), 64'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_cfg_cleared", 64'(bus_a.tickbus), 64'hFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Small corner: NCH=1, CW=2
    bus_b.config_en = 1'b1;
    bus_b.bs_in = 1'b1;
    step();
    cnt = 1;
    bus_b.bs_in = 1'b0;
    while (!bus_b.bs_out && cnt < 20) begin
      step();
      cnt++;
    end
    checkOutput("b_chain_len", 64'(cnt), 64'(chain_len(NB, CB)));
    for (int i = 0; i < 3; i++) begin
      bus_b.bs_in = (i < 2);
      step();
    end
    bus_b.config_en = 1'b0;
    bus_b.sync_clr = 1'b1;
    step();
    bus_b.sync_clr = 1'b0;
    bus_b.run_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!bus_b.tickbus[2] && cnt < 20);
      checkOutput($sformatf("b_period%0d", pass), 64'(cnt), 64'd4);
    end
    bus_b.run_en = 1'b0;

    // Large corner: NCH=16, CW=16, last channel P=5
    bus_c.config_en = 1'b1;
    bus_c.bs_in = 1'b1;
    step();
    cnt = 1;
    bus_c.bs_in = 1'b0;
    while (!bus_c.bs_out && cnt < 600) begin
      step();
      cnt++;
    end
    checkOutput("c_chain_len", 64'(cnt), 64'(chain_len(NC, CC)));
    vecC = '0;
    vecC[16:0] = 17'd5;
    for (int i = 0; i < LC; i++) begin
      bus_c.bs_in = vecC[i];
      step();
    end
    bus_c.config_en = 1'b0;
    bus_c.sync_clr = 1'b1;
    step();
    bus_c.sync_clr = 1'b0;
    bus_c.run_en = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!bus_c.tickbus[17] && cnt < 50);
    checkOutput("c_period", 64'(cnt), 64'd6);
    checkOutput("c_tickbus", 64'(bus_c.tickbus), 64'h3FFFE);
    bus_c.run_en = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
